// File: rtl/alarm_pkg.sv
// Shared alarm timing definitions:
// interval codes, default table, FSM states.
package alarm_pkg;

  localparam logic [1:0] ARM_DELAY       = 2'd0;
  localparam logic [1:0] DRIVER_DELAY    = 2'd1;
  localparam logic [1:0] PASSENGER_DELAY = 2'd2;
  localparam logic [1:0] ALARM_ON        = 2'd3;

  localparam int unsigned T_ARM_DELAY       = 6;
  localparam int unsigned T_DRIVER_DELAY    = 8;
  localparam int unsigned T_PASSENGER_DELAY = 15;
  localparam int unsigned T_ALARM_ON        = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int unsigned default_time(
    input logic [1:0] sel
  );
    int unsigned v;
    v = T_ARM_DELAY;
    unique case (sel)
      ARM_DELAY:       v = T_ARM_DELAY;
      DRIVER_DELAY:    v = T_DRIVER_DELAY;
      PASSENGER_DELAY: v = T_PASSENGER_DELAY;
      ALARM_ON:        v = T_ALARM_ON;
      default:         v = T_ARM_DELAY;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alarm_timer_if.sv
// FSM <-> alarm timer bundle:
// start/reprogram requests and timer status.
interface alarm_timer_if #(
  parameter int WIDTH = 4
);
  logic             start_timer;
  logic [1:0]       interval;
  logic             reprogram;
  logic [1:0]       time_param_sel;
  logic [WIDTH-1:0] time_value;
  logic             expired;
  logic             busy;
  logic [WIDTH-1:0] seconds_left;
  logic             one_hz_enable;

  modport master (
    output start_timer, interval,
    output reprogram, time_param_sel, time_value,
    input  expired, busy, seconds_left, one_hz_enable
  );

  modport slave (
    input  start_timer, interval,
    input  reprogram, time_param_sel, time_value,
    output expired, busy, seconds_left, one_hz_enable
  );
endinterface

// File: rtl/tick_divider.sv
// One-second divider: counts 0..CLK_HZ-1,
// terminal count marks the tick; clear restarts phase.
module tick_divider #(
  parameter int CLK_HZ = 27_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // next count: wrap at terminal, zero on clear
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear || tick) cnt_d = '0;
  end

  // divider register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/alarm_timer.sv
// Alarm countdown: parameter table, countdown FSM
// and expiry pulse for the anti-theft FSM.
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int WIDTH  = 4
) (
  input  logic          clock,
  input  logic          reset,
  alarm_timer_if.slave  bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sl_q, sl_d;
  logic             exp_q, exp_d;
  logic             hz_q, hz_d;
  logic [WIDTH-1:0] tbl_q [4];
  logic [WIDTH-1:0] tbl_d [4];
  logic [WIDTH-1:0] load;
  logic             tick;

  tick_divider #(.CLK_HZ(CLK_HZ)) u_div (
    .clock (clock),
    .reset (reset),
    .clear (bus.start_timer),
    .tick  (tick)
  );

  assign bus.expired       = exp_q;
  assign bus.busy          = (state_q == COUNT);
  assign bus.seconds_left  = sl_q;
  assign bus.one_hz_enable = hz_q;

  // table write; a start in the same cycle sees the old entry
  always_comb begin
    tbl_d = tbl_q;
    if (bus.reprogram) tbl_d[bus.time_param_sel] = bus.time_value;
  end

  // countdown FSM next state and expiry pulse
  always_comb begin
    state_d = state_q;
    sl_d    = sl_q;
    exp_d   = 1'b0;
    load    = tbl_q[bus.interval];
    hz_d    = tick && !bus.start_timer;
    if (bus.start_timer) begin
      sl_d    = load;
      state_d = (load == '0) ? DONE : COUNT;
    end else begin
      unique case (state_q)
        IDLE: ;
        COUNT: begin
          if (tick) begin
            if (sl_q == WIDTH'(1)) begin
              sl_d    = '0;
              state_d = DONE;
              exp_d   = 1'b1;
            end else begin
              sl_d = sl_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          // zero-length loads reach here without a pulse yet
          exp_d   = !exp_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, countdown and table registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sl_q    <= '0;
      exp_q   <= 1'b0;
      hz_q    <= 1'b0;
      for (int i = 0; i < 4; i++)
        tbl_q[i] <= WIDTH'(default_time(2'(i)));
    end else begin
      state_q <= state_d;
      sl_q    <= sl_d;
      exp_q   <= exp_d;
      hz_q    <= hz_d;
      tbl_q   <= tbl_d;
    end
  end
endmodule
